// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state encoding and request classification
// helpers shared by the load/store unit and its load aligner.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // state   | meaning
  // IDLE    | accepting requests; first sub-access of a split op runs here
  // LD_HI   | second word read of a split load, result returned this cycle
  // ST_BYTE | remaining byte writes of a split store
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_HI   = 2'd1,
    ST_BYTE = 2'd2
  } lsu_state_e;

  // 011, 110 and 111 are not load/store widths in RV32I.
  function automatic logic is_invalid(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f3)
      LH, LHU: r = a[0];
      LW:      r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts a misaligned load result from two consecutive memory
// words. The pair {hi,lo} is shifted down by the byte offset, then halfwords
// are sign- or zero-extended and words are passed as-is.
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_lo,
  input  logic [DATA_WIDTH-1:0] i_hi,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [2*DATA_WIDTH-1:0] w_pair;
  logic [DATA_WIDTH-1:0]   w_shifted;

  // Shift the word pair by the byte offset and apply the load extension
  always_comb begin
    w_pair    = {i_hi, i_lo};
    w_shifted = DATA_WIDTH'(w_pair >> {i_offset, 3'b000});
    case (i_funct3)
      LH:      o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      LHU:     o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage load/store unit.
// Aligned requests pass straight through to the data memory in the same cycle.
// Build option LSU_MISALIGN_EN: when defined, misaligned loads become two word
// reads and misaligned stores become a train of byte writes; when undefined,
// misaligned requests are only flagged and have no memory side effect.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  misaligned_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  logic w_misaligned;
  logic w_invalid;

  // Classify the incoming request
  always_comb begin
    w_misaligned = is_misaligned(req_funct3, req_addr[1:0]);
    w_invalid    = is_invalid(req_funct3);
  end

`ifdef LSU_MISALIGN_EN

  lsu_state_e            r_state;
  logic [1:0]            r_cnt;
  logic [1:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_base = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .i_lo     (r_lo),
    .i_hi     (mem_rd_data),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_data)
  );

  // Sequencer: latch the split request in IDLE, then walk LD_HI or ST_BYTE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_idx    <= 2'd0;
      r_addr   <= '0;
      r_funct3 <= 3'b000;
      r_wdata  <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && w_misaligned) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            if (req_we) begin
              // byte 0 goes out this cycle; cnt counts the writes still owed
              r_wdata <= req_wdata;
              r_cnt   <= (req_funct3 == SW) ? 2'd3 : 2'd1;
              r_idx   <= 2'd1;
              r_state <= ST_BYTE;
            end else begin
              r_lo    <= mem_rd_data;
              r_state <= LD_HI;
            end
          end
        end
        LD_HI: begin
          r_state <= IDLE;
        end
        ST_BYTE: begin
          r_cnt <= r_cnt - 2'd1;
          r_idx <= r_idx + 2'd1;
          if (r_cnt == 2'd1) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory-side and response outputs for each state
  always_comb begin
    stall          = 1'b0;
    misaligned_err = 1'b0;
    mem_wr_en      = 1'b0;
    mem_funct3     = req_funct3;
    mem_addr       = req_addr;
    mem_wr_data    = req_wdata;
    rsp_data       = mem_rd_data;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_invalid) begin
            rsp_data = '0;
          end else if (w_misaligned) begin
            misaligned_err = 1'b1;
            stall          = 1'b1;
            if (req_we) begin
              mem_wr_en  = 1'b1;
              mem_funct3 = SB;
            end else begin
              mem_addr   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_funct3 = LW;
            end
          end else begin
            mem_wr_en = req_we;
          end
        end
      end
      LD_HI: begin
        mem_addr    = w_base + ADDR_WIDTH'(4);
        mem_funct3  = LW;
        mem_wr_data = '0;
        rsp_data    = w_ld_data;
      end
      ST_BYTE: begin
        mem_wr_en   = 1'b1;
        mem_funct3  = SB;
        mem_addr    = r_addr + ADDR_WIDTH'(r_idx);
        mem_wr_data = r_wdata >> {r_idx, 3'b000};
        stall       = (r_cnt != 2'd1);
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    // reset must silence the memory port at once, even with a request present
    if (!rst_n) begin
      stall     = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

`else

  // Without split support the unit is purely combinational; clk has no load.
  logic w_unused_clk;
  assign w_unused_clk = clk;

  // Pass-through with misaligned and invalid requests suppressed
  always_comb begin
    stall          = 1'b0;
    misaligned_err = 1'b0;
    mem_wr_en      = 1'b0;
    mem_funct3     = req_funct3;
    mem_addr       = req_addr;
    mem_wr_data    = req_wdata;
    rsp_data       = mem_rd_data;
    if (req_valid) begin
      if (w_invalid) begin
        rsp_data = '0;
      end else if (w_misaligned) begin
        misaligned_err = 1'b1;
        rsp_data       = '0;
      end else begin
        mem_wr_en = req_we;
      end
    end
    if (!rst_n) begin
      mem_wr_en = 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of the load/store unit against a small
// word-addressed data memory model with RV32I load extension and byte lanes.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rsp_data;
  logic        misaligned_err;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [0:63];
  logic [31:0] rd_word;
  logic [31:0] rd_shift;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .rsp_data       (rsp_data),
    .misaligned_err (misaligned_err),
    .mem_wr_en      (mem_wr_en),
    .mem_funct3     (mem_funct3),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data    (mem_rd_data)
  );

  // Combinational memory read with load extension
  always_comb begin
    rd_word  = mem[mem_addr[7:2]];
    rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  mem_rd_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  mem_rd_data = {24'h0, rd_shift[7:0]};
      3'b101:  mem_rd_data = {16'h0, rd_shift[15:0]};
      default: mem_rd_data = rd_word;
    endcase
  end

  // Memory write with byte/halfword lanes
  always @(posedge clk) begin
    if (mem_wr_en) begin
      case (mem_funct3[1:0])
        2'b00:   mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wr_data[7:0];
        2'b01:   mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wr_data[15:0];
        default: mem[mem_addr[7:2]] <= mem_wr_data;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk);
    check({tag, "_rsp"}, rsp_data, exp);
    check({tag, "_err"}, {31'h0, misaligned_err}, 32'h0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, SW, 32'h8, 32'h11111111);
    mem_clear();
    #3;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);

    @(negedge clk);
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    rst_n = 1'b1;
    mem[0] <= 32'h0000001C;
    mem[1] <= 32'h00000010;
    next_cycle();

    // idle: a would-be misaligned store with valid low does nothing
    drive(1'b0, 1'b1, SW, 32'h2, 32'h12345678);
    @(negedge clk);
    check("idle_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("idle_stall", {31'h0, stall}, 32'h0);
    check("idle_err", {31'h0, misaligned_err}, 32'h0);
    next_cycle();

    // aligned lw at 0x4, same cycle
    drive(1'b1, 1'b0, LW, 32'h4, 32'h0);
    @(negedge clk);
    check("lw4_rsp", rsp_data, 32'h00000010);
    check("lw4_stall", {31'h0, stall}, 32'h0);
    check("lw4_addr", mem_addr, 32'h4);
    next_cycle();

    // aligned sw at 0x8
    drive(1'b1, 1'b1, SW, 32'h8, 32'h8081F27F);
    @(negedge clk);
    check("sw8_wr_en", {31'h0, mem_wr_en}, 32'h1);
    check("sw8_stall", {31'h0, stall}, 32'h0);
    check("sw8_data", mem_wr_data, 32'h8081F27F);
    next_cycle();
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    check("sw8_mem", mem[2], 32'h8081F27F);

    // aligned narrow loads, including odd byte addresses
    load_check("lb_b", LB, 32'hB, 32'hFFFFFF80);
    load_check("lbu_b", LBU, 32'hB, 32'h00000080);
    load_check("lb_9", LB, 32'h9, 32'hFFFFFFF2);
    load_check("lh_a", LH, 32'hA, 32'hFFFF8081);
    load_check("lhu_8", LHU, 32'h8, 32'h0000F27F);

    // aligned sb then sh into word 3
    drive(1'b1, 1'b1, SB, 32'hD, 32'hFFFFFF5A);
    @(negedge clk);
    check("sb_err", {31'h0, misaligned_err}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, SH, 32'hE, 32'h00001234);
    next_cycle();
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    check("sb_sh_mem", mem[3], 32'h12345A00);

    // invalid funct3: load returns zero, store does not write
    drive(1'b1, 1'b0, 3'b011, 32'h4, 32'h0);
    @(negedge clk);
    check("inv_ld_rsp", rsp_data, 32'h0);
    check("inv_ld_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 3'b111, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("inv_st_wr_en", {31'h0, mem_wr_en}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    check("inv_st_mem", mem[4], 32'h0);

`ifdef LSU_MISALIGN_EN
    // split lw at 0x2; req_* scrambled during LD_HI must be ignored
    drive(1'b1, 1'b0, LW, 32'h2, 32'h0);
    @(negedge clk);
    check("mlw_stall0", {31'h0, stall}, 32'h1);
    check("mlw_err0", {31'h0, misaligned_err}, 32'h1);
    check("mlw_addr0", mem_addr, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, LB, 32'h21, 32'h0);
    @(negedge clk);
    check("mlw_rsp1", rsp_data, 32'h00100000);
    check("mlw_stall1", {31'h0, stall}, 32'h0);
    check("mlw_addr1", mem_addr, 32'h4);
    next_cycle();

    // split lh / lhu at 0x3
    mem[0] <= 32'hFF000000;
    mem[1] <= 32'h00000080;
    drive(1'b1, 1'b0, LH, 32'h3, 32'h0);
    @(negedge clk);
    check("mlh_stall0", {31'h0, stall}, 32'h1);
    check("mlh_f3_0", {29'h0, mem_funct3}, 32'h2);
    next_cycle();
    @(negedge clk);
    check("mlh_rsp", rsp_data, 32'hFFFF80FF);
    next_cycle();
    drive(1'b1, 1'b0, LHU, 32'h3, 32'h0);
    next_cycle();
    @(negedge clk);
    check("mlhu_rsp", rsp_data, 32'h000080FF);
    next_cycle();

    // split sw at 0xD1: four byte writes
    mem_clear();
    drive(1'b1, 1'b1, SW, 32'hD1, 32'hAABBCCDD);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("msw_stall%0d", k), {31'h0, stall}, (k < 3) ? 32'h1 : 32'h0);
      check($sformatf("msw_wr_en%0d", k), {31'h0, mem_wr_en}, 32'h1);
      check($sformatf("msw_addr%0d", k), mem_addr, 32'hD1 + k);
      check($sformatf("msw_byte%0d", k), {24'h0, mem_wr_data[7:0]},
            {24'h0, 8'(32'hAABBCCDD >> (8 * k))});
      next_cycle();
    end
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    check("msw_w52", mem[52], 32'hBBCCDD00);
    check("msw_w53", mem[53], 32'h000000AA);

    // same store, reset after the second write
    mem_clear();
    drive(1'b1, 1'b1, SW, 32'hD1, 32'hAABBCCDD);
    next_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    #1;
    check("rsw_stall", {31'h0, stall}, 32'h0);
    check("rsw_wr_en", {31'h0, mem_wr_en}, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    check("rsw_w52", mem[52], 32'h00CCDD00);
    check("rsw_w53", mem[53], 32'h0);
`else
    // misaligned lw at 0x2 is flagged and dropped
    drive(1'b1, 1'b0, LW, 32'h2, 32'h0);
    @(negedge clk);
    check("nlw_err", {31'h0, misaligned_err}, 32'h1);
    check("nlw_rsp", rsp_data, 32'h0);
    check("nlw_stall", {31'h0, stall}, 32'h0);
    check("nlw_wr_en", {31'h0, mem_wr_en}, 32'h0);
    next_cycle();

    // misaligned lh at 0x1
    drive(1'b1, 1'b0, LH, 32'h1, 32'h0);
    @(negedge clk);
    check("nlh_err", {31'h0, misaligned_err}, 32'h1);
    check("nlh_rsp", rsp_data, 32'h0);
    next_cycle();

    // misaligned sw at 0xD1 writes nothing
    drive(1'b1, 1'b1, SW, 32'hD1, 32'hAABBCCDD);
    @(negedge clk);
    check("nsw_err", {31'h0, misaligned_err}, 32'h1);
    check("nsw_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("nsw_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0);
    check("nsw_w52", mem[52], 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, byte-address width; DATA_WIDTH, default 32, data width.
REQ-002 SHALL have these ports, in this order:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage request present
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- stall  out  1  hold pipeline; request must stay stable
- rsp_data  out  DATA_WIDTH  load result, extended per funct3
- misaligned_err  out  1  misaligned access flagged
- mem_wr_en  out  1  to data memory
- mem_funct3  out  3  to data memory
- mem_addr  out  ADDR_WIDTH  to data memory
- mem_wr_data  out  DATA_WIDTH  to data memory
- mem_rd_data  in  DATA_WIDTH  combinational read data from data memory

Function
REQ-003 SHALL classify a request as misaligned when funct3 is 001/101 with addr[0]=1, or 010 with addr[1:0]!=0; byte accesses are never misaligned.
REQ-004 SHALL pass aligned requests through combinationally in the same cycle: mem_* = req_*, mem_wr_en = req_valid & req_we, rsp_data = mem_rd_data, stall = 0.
REQ-005 SHALL use FSM states IDLE, LD_HI and ST_BYTE; the request cycle, including the first sub-access, executes in IDLE.
REQ-006 Misaligned load, IDLE cycle: mem_addr = {addr[31:2],2'b00}, mem_funct3 = 010; SHALL register mem_rd_data into lo_q, register addr/funct3, assert stall, and go to LD_HI.
REQ-007 LD_HI: mem_addr = base+4 (mod 2^ADDR_WIDTH), mem_funct3 = 010; SHALL form rsp_data = ({mem_rd_data,lo_q} >> 8*offset), sign-extend (001) or zero-extend (101) halfwords, drive stall = 0, and return to IDLE. Total latency is 2 cycles.
REQ-008 Misaligned store: SHALL latch addr, wdata and byte count n (2 for sh, 4 for sw), then issue n sb writes (mem_funct3 = 000), byte k of wdata to addr+k, one per cycle starting in the IDLE cycle.
- stall = 1 on every write except the last.
- Remaining writes are tracked by a 2-bit counter in ST_BYTE.
- The FSM returns to IDLE after the last write.
REQ-009 While busy (LD_HI or ST_BYTE), SHALL ignore req_* and use only latched values.
REQ-010 Invalid funct3 (011, 110, 111): SHALL drive mem_wr_en = 0, rsp_data = 0 and stall = 0.
REQ-011 When req_valid = 0 in IDLE: mem_wr_en = 0, stall = 0, misaligned_err = 0.
REQ-012 misaligned_err SHALL be combinational, high in the IDLE cycle of any valid misaligned request.

Reset
REQ-013 Asserting rst_n low SHALL immediately force:
- state to IDLE and counter to 0
- lo_q and latched registers to 0
- stall = 0, mem_wr_en = 0
REQ-014 Reset mid-operation SHALL abort the operation: no further byte writes are issued, and bytes already written remain in memory.

Configuration
REQ-015 Macro LSU_MISALIGN_EN defined: misaligned accesses SHALL be split per REQ-006..008.
REQ-016 Macro LSU_MISALIGN_EN undefined: misaligned requests SHALL assert misaligned_err with mem_wr_en = 0, rsp_data = 0 and stall = 0; LD_HI and ST_BYTE logic is not built.

Structure
REQ-017 Shared package lsu_pkg SHALL hold the funct3 constants (LB..LHU, SB/SH/SW) and the FSM state encoding.
REQ-018 Sub-module load_align SHALL implement the purely combinational shift and extension of REQ-007.

Verification
REQ-019 Memory word0 = 0x0000001C, word1 = 0x00000010; lw at 0x4 -> same cycle rsp_data = 0x00000010, stall = 0.
REQ-020 Same memory contents; lw at 0x2 -> cycle 0 stall = 1, misaligned_err = 1; cycle 1 rsp_data = 0x00100000, stall = 0.
REQ-021 Memory word0 = 0xFF000000, word1 = 0x00000080; lh at 0x3 -> rsp_data 0xFFFF80FF; lhu at 0x3 -> rsp_data 0x000080FF.
REQ-022 sw 0xAABBCCDD at 0xD1, memory zero -> 4 sb writes over 4 cycles, stall 1,1,1,0; word 52 = 0xBBCCDD00, word 53 = 0x000000AA.
REQ-023 Same sw with rst_n pulsed low after the 2nd write -> stall 0 at once, no further writes; word 52 = 0x00CCDD00, word 53 = 0.
REQ-024 LSU_MISALIGN_EN undefined; lw at 0x2 -> misaligned_err = 1, rsp_data = 0, stall = 0, mem_wr_en = 0.
